// File: rtl/nx_node.sv
// nx_node -- one tile of a 2-D mesh of programmable logic nodes.
// Messages are routed row-first, then column. Each outbound direction holds
// at most one message. Messages addressed to this node program a small
// gate-level core (instruction memory, input/output state, output-to-mesh map).
// A trigger runs the program once and then announces changed outputs as
// INPUT messages to their mapped destinations.
module nx_node #(
  parameter int STREAM_WIDTH   = 32,
  parameter int ADDR_ROW_WIDTH = 4,
  parameter int ADDR_COL_WIDTH = 4,
  parameter int COMMAND_WIDTH  = 2,
  parameter int INSTR_WIDTH    = 15,
  parameter int INPUTS         = 8,
  parameter int OUTPUTS        = 8,
  parameter int REGISTERS      = 8,
  parameter int MAX_INSTRS     = 512,
  parameter int OPCODE_WIDTH   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      trigger_i,
  input  logic [ADDR_ROW_WIDTH-1:0] node_row_i,
  input  logic [ADDR_COL_WIDTH-1:0] node_col_i,

  input  logic [STREAM_WIDTH-1:0]   ib_north_data_i,
  input  logic                      ib_north_valid_i,
  output logic                      ib_north_ready_o,
  input  logic [STREAM_WIDTH-1:0]   ib_east_data_i,
  input  logic                      ib_east_valid_i,
  output logic                      ib_east_ready_o,
  input  logic [STREAM_WIDTH-1:0]   ib_south_data_i,
  input  logic                      ib_south_valid_i,
  output logic                      ib_south_ready_o,
  input  logic [STREAM_WIDTH-1:0]   ib_west_data_i,
  input  logic                      ib_west_valid_i,
  output logic                      ib_west_ready_o,

  output logic [STREAM_WIDTH-1:0]   ob_north_data_o,
  output logic                      ob_north_valid_o,
  input  logic                      ob_north_ready_i,
  output logic [STREAM_WIDTH-1:0]   ob_east_data_o,
  output logic                      ob_east_valid_o,
  input  logic                      ob_east_ready_i,
  output logic [STREAM_WIDTH-1:0]   ob_south_data_o,
  output logic                      ob_south_valid_o,
  input  logic                      ob_south_ready_i,
  output logic [STREAM_WIDTH-1:0]   ob_west_data_o,
  output logic                      ob_west_valid_o,
  input  logic                      ob_west_ready_i
);

  localparam int NUM_PORTS = 4;
  localparam int ROW_LSB   = STREAM_WIDTH - ADDR_ROW_WIDTH;
  localparam int COL_LSB   = ROW_LSB - ADDR_COL_WIDTH;
  localparam int CMD_LSB   = COL_LSB - COMMAND_WIDTH;
  localparam int PAY_W     = CMD_LSB;
  localparam int PC_W      = $clog2(MAX_INSTRS);
  localparam int CNT_W     = $clog2(MAX_INSTRS + 1);
  localparam int IDX_W     = 3;

  // Port order N,E,S,W doubles as the round-robin order and the index into
  // the per-direction holding registers.
  typedef enum logic [2:0] {
    DIR_N     = 3'd0,
    DIR_E     = 3'd1,
    DIR_S     = 3'd2,
    DIR_W     = 3'd3,
    DIR_LOCAL = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    CMD_LOAD_INSTR = 2'd0,
    CMD_INPUT      = 2'd1,
    CMD_MAP_OUTPUT = 2'd2,
    CMD_DISCARD    = 2'd3
  } cmd_e;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_NAND = 3'd2,
    OP_OR   = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_BUF  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_EMIT
  } state_e;

  // Dimension-ordered routing: resolve the row first, then the column.
  function automatic dir_e route(input logic [ADDR_ROW_WIDTH-1:0] t_row,
                                 input logic [ADDR_COL_WIDTH-1:0] t_col,
                                 input logic [ADDR_ROW_WIDTH-1:0] my_row,
                                 input logic [ADDR_COL_WIDTH-1:0] my_col);
    if (t_row > my_row)      return DIR_S;
    else if (t_row < my_row) return DIR_N;
    else if (t_col > my_col) return DIR_E;
    else if (t_col < my_col) return DIR_W;
    else                     return DIR_LOCAL;
  endfunction

  // ---------------------------------------------------------------------
  // Port packing
  // ---------------------------------------------------------------------
  logic [NUM_PORTS-1:0]    ib_valid;
  logic [STREAM_WIDTH-1:0] ib_data [NUM_PORTS];
  logic [NUM_PORTS-1:0]    ib_ready;
  logic [NUM_PORTS-1:0]    ob_ready;

  assign ib_valid   = {ib_west_valid_i, ib_south_valid_i, ib_east_valid_i, ib_north_valid_i};
  assign ib_data[0] = ib_north_data_i;
  assign ib_data[1] = ib_east_data_i;
  assign ib_data[2] = ib_south_data_i;
  assign ib_data[3] = ib_west_data_i;
  assign ob_ready   = {ob_west_ready_i, ob_south_ready_i, ob_east_ready_i, ob_north_ready_i};

  assign ib_north_ready_o = ib_ready[0];
  assign ib_east_ready_o  = ib_ready[1];
  assign ib_south_ready_o = ib_ready[2];
  assign ib_west_ready_o  = ib_ready[3];

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [NUM_PORTS-1:0]    ob_valid_q, ob_valid_d;
  logic [STREAM_WIDTH-1:0] ob_data_q [NUM_PORTS];
  logic [STREAM_WIDTH-1:0] ob_data_d [NUM_PORTS];
  logic [1:0]              rr_q;

  logic [INSTR_WIDTH-1:0]    imem [MAX_INSTRS];
  logic [CNT_W-1:0]          count_q;
  logic [INPUTS-1:0]         in_q, in_d;
  logic [INPUTS-1:0]         snap_q;
  logic [REGISTERS-1:0]      regs_q;
  logic [OUTPUTS-1:0]        outs_q;
  logic [OUTPUTS-1:0]        last_q;
  logic [OUTPUTS-1:0]        map_valid_q;
  logic [ADDR_ROW_WIDTH-1:0] map_row_q [OUTPUTS];
  logic [ADDR_COL_WIDTH-1:0] map_col_q [OUTPUTS];
  logic [IDX_W-1:0]          map_in_q  [OUTPUTS];

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [IDX_W-1:0] emit_idx_q, emit_idx_d;

  // ---------------------------------------------------------------------
  // Inbound routing and round-robin arbitration
  // ---------------------------------------------------------------------
  dir_e                 ib_dir [NUM_PORTS];
  logic [NUM_PORTS-1:0] port_free;
  logic                 grant_valid;
  logic [1:0]           grant_port;

  // Route every inbound head; a port may only win if its destination can take it.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      ib_dir[p]    = route(ib_data[p][ROW_LSB +: ADDR_ROW_WIDTH],
                           ib_data[p][COL_LSB +: ADDR_COL_WIDTH],
                           node_row_i, node_col_i);
      port_free[p] = (ib_dir[p] == DIR_LOCAL) || !ob_valid_q[ib_dir[p][1:0]];
    end
  end

  // Pick the first eligible port starting at the round-robin pointer.
  always_comb begin
    logic [1:0] scan_port;
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    scan_port   = '0;
    grant_valid = 1'b0;
    grant_port  = rr_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_port = rr_q + 2'(i);
      if (!grant_valid && ib_valid[scan_port] && port_free[scan_port]) begin
        grant_valid = 1'b1;
        grant_port  = scan_port;
      end
    end
  end

  // Ready is held low while in reset even though the holding registers are empty.
  assign ib_ready = (grant_valid && !rst_i) ? (4'b0001 << grant_port) : 4'b0000;

  logic [STREAM_WIDTH-1:0] gnt_data;
  dir_e                    gnt_dir;
  cmd_e                    gnt_cmd;
  logic                    gnt_local;

  assign gnt_data  = ib_data[grant_port];
  assign gnt_dir   = ib_dir[grant_port];
  assign gnt_cmd   = cmd_e'(gnt_data[CMD_LSB +: COMMAND_WIDTH]);
  assign gnt_local = grant_valid && (gnt_dir == DIR_LOCAL);

  // Round-robin pointer names the port that gets first look next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= 2'd0;
    end else if (grant_valid) begin
      // NOTE: clocked state is always updated with <= so every register
      // samples pre-edge values regardless of block evaluation order.
      rr_q <= grant_port + 2'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Generated (emit-phase) messages
  // ---------------------------------------------------------------------
  logic                    emit_val;
  logic                    emit_need;
  logic [STREAM_WIDTH-1:0] gen_msg;
  dir_e                    gen_dir;
  logic                    gen_ok;
  logic                    gen_fire;
  logic                    emit_advance;

  assign emit_val  = outs_q[emit_idx_q];
  assign emit_need = (state_q == S_EMIT) && map_valid_q[emit_idx_q] &&
                     (emit_val != last_q[emit_idx_q]);
  assign gen_msg   = {map_row_q[emit_idx_q], map_col_q[emit_idx_q], CMD_INPUT,
                      {(PAY_W-IDX_W-1){1'b0}}, emit_val, map_in_q[emit_idx_q]};
  assign gen_dir   = route(map_row_q[emit_idx_q], map_col_q[emit_idx_q],
                           node_row_i, node_col_i);

  // Forwarded traffic wins a holding register; the generated message waits.
  assign gen_ok       = (gen_dir == DIR_LOCAL) ||
                        (!ob_valid_q[gen_dir[1:0]] &&
                         !(grant_valid && (gnt_dir == gen_dir)));
  assign gen_fire     = emit_need && gen_ok;
  assign emit_advance = (state_q == S_EMIT) && (!emit_need || gen_ok);

  // ---------------------------------------------------------------------
  // Outbound holding registers
  // ---------------------------------------------------------------------
  // Free on handshake, then load from the granted inbound or the emit phase.
  always_comb begin
    ob_valid_d = ob_valid_q;
    ob_data_d  = ob_data_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (ob_valid_q[p] && ob_ready[p]) ob_valid_d[p] = 1'b0;
    end
    if (grant_valid && (gnt_dir != DIR_LOCAL)) begin
      ob_valid_d[gnt_dir[1:0]] = 1'b1;
      ob_data_d[gnt_dir[1:0]]  = gnt_data;
    end
    if (gen_fire && (gen_dir != DIR_LOCAL)) begin
      ob_valid_d[gen_dir[1:0]] = 1'b1;
      ob_data_d[gen_dir[1:0]]  = gen_msg;
    end
  end

  // Holding register state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ob_valid_q <= '0;
      ob_data_q  <= '{default: '0};
    end else begin
      ob_valid_q <= ob_valid_d;
      ob_data_q  <= ob_data_d;
    end
  end

  assign ob_north_valid_o = ob_valid_q[0];
  assign ob_east_valid_o  = ob_valid_q[1];
  assign ob_south_valid_o = ob_valid_q[2];
  assign ob_west_valid_o  = ob_valid_q[3];
  assign ob_north_data_o  = ob_data_q[0];
  assign ob_east_data_o   = ob_data_q[1];
  assign ob_south_data_o  = ob_data_q[2];
  assign ob_west_data_o   = ob_data_q[3];

  // ---------------------------------------------------------------------
  // Local configuration: instruction memory, count, output map
  // ---------------------------------------------------------------------
  logic load_en;
  assign load_en = gnt_local && (gnt_cmd == CMD_LOAD_INSTR) &&
                   (count_q != CNT_W'(MAX_INSTRS));

  // Instruction store; only entries below count_q are ever executed.
  always_ff @(posedge clk_i) begin
    // NOTE: the memory array has no reset; count_q gates which entries are
    // live, so clearing it would only cost a large reset fan-out.
    if (load_en) imem[count_q[PC_W-1:0]] <= gnt_data[INSTR_WIDTH-1:0];
  end

  // Instruction count and output-to-mesh mapping table.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q     <= '0;
      map_valid_q <= '0;
      map_row_q   <= '{default: '0};
      map_col_q   <= '{default: '0};
      map_in_q    <= '{default: '0};
    end else begin
      if (load_en) count_q <= count_q + CNT_W'(1);
      if (gnt_local && (gnt_cmd == CMD_MAP_OUTPUT)) begin
        map_valid_q[gnt_data[2:0]] <= 1'b1;
        map_row_q[gnt_data[2:0]]   <= gnt_data[6:3];
        map_col_q[gnt_data[2:0]]   <= gnt_data[10:7];
        map_in_q[gnt_data[2:0]]    <= gnt_data[13:11];
      end
    end
  end

  // Live input vector: inbound INPUT first, then a self-addressed emit.
  always_comb begin
    in_d = in_q;
    if (gnt_local && (gnt_cmd == CMD_INPUT)) in_d[gnt_data[2:0]] = gnt_data[3];
    if (gen_fire && (gen_dir == DIR_LOCAL))  in_d[map_in_q[emit_idx_q]] = emit_val;
  end

  // Live input vector register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) in_q <= '0;
    else       in_q <= in_d;
  end

  // ---------------------------------------------------------------------
  // Execution core
  // ---------------------------------------------------------------------
  logic [INSTR_WIDTH-1:0] instr;
  op_e                    op;
  logic                   opnd_a, opnd_b, result;
  logic                   exec_en, snap_load;

  assign instr  = imem[pc_q];
  assign op     = op_e'(instr[14:12]);
  assign opnd_a = instr[11] ? snap_q[instr[10:8]] : regs_q[instr[10:8]];
  assign opnd_b = instr[7]  ? snap_q[instr[6:4]]  : regs_q[instr[6:4]];

  // Single-bit ALU.
  always_comb begin
    result = opnd_a;
    case (op)
      OP_NOT:  result = ~opnd_a;
      OP_AND:  result = opnd_a & opnd_b;
      OP_NAND: result = ~(opnd_a & opnd_b);
      OP_OR:   result = opnd_a | opnd_b;
      OP_NOR:  result = ~(opnd_a | opnd_b);
      OP_XOR:  result = opnd_a ^ opnd_b;
      OP_XNOR: result = ~(opnd_a ^ opnd_b);
      OP_BUF:  result = opnd_a;
      default: result = opnd_a;
    endcase
  end

  // Sequencer: idle -> execute count instructions -> emit changed outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    emit_idx_d = emit_idx_q;
    exec_en    = 1'b0;
    snap_load  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger_i && (count_q != '0)) begin
          state_d   = S_EXEC;
          pc_d      = '0;
          snap_load = 1'b1;
        end
      end
      S_EXEC: begin
        exec_en = 1'b1;
        if ((CNT_W'(pc_q) + CNT_W'(1)) == count_q) begin
          state_d    = S_EMIT;
          emit_idx_d = '0;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      S_EMIT: begin
        if (emit_advance) begin
          if (emit_idx_q == IDX_W'(OUTPUTS - 1)) state_d = S_IDLE;
          else                                   emit_idx_d = emit_idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      emit_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      emit_idx_q <= emit_idx_d;
    end
  end

  // Snapshot, register file, outputs and last-emitted values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap_q <= '0;
      regs_q <= '0;
      outs_q <= '0;
      last_q <= '0;
    end else begin
      if (snap_load) snap_q <= in_q;
      if (exec_en) begin
        regs_q[instr[2:0]] <= result;
        if (instr[3]) outs_q[instr[2:0]] <= result;
      end
      if (gen_fire) last_q[emit_idx_q] <= emit_val;
    end
  end

endmodule

// File: tb/tb_nx_node.sv
// Directed bench for nx_node placed at mesh address (2,2).
module tb_nx_node;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        trigger_i;
  logic [3:0]  node_row_i = 4'd2;
  logic [3:0]  node_col_i = 4'd2;
  logic [3:0]  ib_valid;
  logic [31:0] ib_data [4];
  logic [3:0]  ob_ready;
  wire  [3:0]  ib_ready;
  wire  [3:0]  ob_valid;
  wire  [31:0] ob_d_n, ob_d_e, ob_d_s, ob_d_w;

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] xfer_log [$];

  localparam logic [14:0] I_AND01 = 15'h1898;  // AND in0,in1 -> r0, drive out0
  localparam logic [14:0] I_BUF5  = 15'h7D09;  // BUF in5 -> r1, drive out1
  localparam logic [14:0] I_NOT0  = 15'h0808;  // NOT in0 -> r0, drive out0

  always #5 clk_i = ~clk_i;

  nx_node dut (
    .clk_i(clk_i), .rst_i(rst_i), .trigger_i(trigger_i),
    .node_row_i(node_row_i), .node_col_i(node_col_i),
    .ib_north_data_i(ib_data[0]), .ib_north_valid_i(ib_valid[0]), .ib_north_ready_o(ib_ready[0]),
    .ib_east_data_i (ib_data[1]), .ib_east_valid_i (ib_valid[1]), .ib_east_ready_o (ib_ready[1]),
    .ib_south_data_i(ib_data[2]), .ib_south_valid_i(ib_valid[2]), .ib_south_ready_o(ib_ready[2]),
    .ib_west_data_i (ib_data[3]), .ib_west_valid_i (ib_valid[3]), .ib_west_ready_o (ib_ready[3]),
    .ob_north_data_o(ob_d_n), .ob_north_valid_o(ob_valid[0]), .ob_north_ready_i(ob_ready[0]),
    .ob_east_data_o (ob_d_e), .ob_east_valid_o (ob_valid[1]), .ob_east_ready_i (ob_ready[1]),
    .ob_south_data_o(ob_d_s), .ob_south_valid_o(ob_valid[2]), .ob_south_ready_i(ob_ready[2]),
    .ob_west_data_o (ob_d_w), .ob_west_valid_o (ob_valid[3]), .ob_west_ready_i (ob_ready[3])
  );

  function automatic logic [31:0] obd(input int p);
    case (p)
      0:       return ob_d_n;
      1:       return ob_d_e;
      2:       return ob_d_s;
      default: return ob_d_w;
    endcase
  endfunction

  function automatic logic [31:0] msg(input logic [3:0] row, input logic [3:0] col,
                                      input logic [1:0] cmd, input logic [21:0] pay);
    return {row, col, cmd, pay};
  endfunction

  function automatic logic [21:0] map_pay(input logic [2:0] o, input logic [3:0] row,
                                          input logic [3:0] col, input logic [2:0] idx);
    return {8'd0, idx, col, row, o};
  endfunction

  function automatic logic [21:0] in_pay(input logic [2:0] idx, input logic val);
    return {18'd0, val, idx};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every completed outbound handshake, tagged with its port.
  always @(negedge clk_i) begin
    #1;
    if (!rst_i) begin
      for (int p = 0; p < 4; p++)
        if (ob_valid[p] && ob_ready[p]) xfer_log.push_back({2'(p), obd(p)});
    end
  end

  // Present one message on inbound port p until accepted (called at a negedge).
  task automatic send(input int p, input logic [31:0] d);
    bit got;
    got = 1'b0;
    ib_data[p]  = d;
    ib_valid[p] = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (ib_ready[p]) got = 1'b1;
      @(negedge clk_i);
    end
    ib_valid[p] = 1'b0;
    check("send_accepted", got, 1);
  endtask

  task automatic local_cmd(input logic [1:0] cmd, input logic [21:0] pay);
    send(0, msg(4'd2, 4'd2, cmd, pay));
  endtask

  task automatic pulse_trigger();
    trigger_i = 1'b1;
    @(negedge clk_i);
    trigger_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    trigger_i = 1'b0;
    ib_valid  = 4'h0;
    ob_ready  = 4'hF;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    xfer_log.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a_msg, b_msg, dmsg;
    bit seen;

    // Reset state, with all inbound ports requesting.
    rst_i     = 1'b1;
    trigger_i = 1'b0;
    ob_ready  = 4'hF;
    ib_valid  = 4'hF;
    for (int p = 0; p < 4; p++) ib_data[p] = msg(4'd2, 4'd2, 2'd3, 22'd0);
    @(negedge clk_i);
    #1;
    check("rst_ob_valid", ob_valid, 4'h0);
    check("rst_ib_ready", ib_ready, 4'h0);
    check("rst_ob_north_data", ob_d_n, 32'h0);
    do_reset();

    // Routing from node (2,2): one message per direction, then a local one.
    send(0, 32'h02C0_1234);
    check("route_n_valid", ob_valid, 4'b0001);
    check("route_n_data", ob_d_n, 32'h02C0_1234);
    send(0, 32'h25C0_0001);
    check("route_e_valid", ob_valid, 4'b0010);
    check("route_e_data", ob_d_e, 32'h25C0_0001);
    send(1, 32'h32C0_0007);
    check("route_s_valid", ob_valid, 4'b0100);
    check("route_s_data", ob_d_s, 32'h32C0_0007);
    send(2, 32'h21C0_0009);
    check("route_w_valid", ob_valid, 4'b1000);
    check("route_w_data", ob_d_w, 32'h21C0_0009);
    send(3, 32'h22C0_0005);
    check("route_local_valid", ob_valid, 4'b0000);

    // AND(in0,in1)->out0 mapped to self idx5: consumed locally, no traffic.
    do_reset();
    local_cmd(2'd2, map_pay(3'd0, 4'd2, 4'd2, 3'd5));
    local_cmd(2'd0, {7'd0, I_AND01});
    local_cmd(2'd1, in_pay(3'd0, 1'b1));
    local_cmd(2'd1, in_pay(3'd1, 1'b1));
    xfer_log.delete();
    pulse_trigger();
    repeat (20) @(negedge clk_i);
    check("self_map_no_traffic", xfer_log.size(), 0);
    // in5 is now 1: buffer it to out1, mapped north to (0,2) idx6.
    local_cmd(2'd0, {7'd0, I_BUF5});
    local_cmd(2'd2, map_pay(3'd1, 4'd0, 4'd2, 3'd6));
    xfer_log.delete();
    pulse_trigger();
    repeat (20) @(negedge clk_i);
    check("self_in5_count", xfer_log.size(), 1);
    check("self_in5_msg", xfer_log[0], {2'd0, 32'h0240_000E});

    // out0 mapped to (0,2) idx3: first run emits north, rerun is silent.
    do_reset();
    local_cmd(2'd2, map_pay(3'd0, 4'd0, 4'd2, 3'd3));
    local_cmd(2'd0, {7'd0, I_AND01});
    local_cmd(2'd1, in_pay(3'd0, 1'b1));
    local_cmd(2'd1, in_pay(3'd1, 1'b1));
    xfer_log.delete();
    pulse_trigger();
    repeat (20) @(negedge clk_i);
    check("emit_count", xfer_log.size(), 1);
    check("emit_msg", xfer_log[0], {2'd0, 32'h0240_000B});
    xfer_log.delete();
    pulse_trigger();
    repeat (20) @(negedge clk_i);
    check("emit_unchanged_silent", xfer_log.size(), 0);

    // Eastbound back-pressure: first held stable, second stalls inbound.
    do_reset();
    a_msg = msg(4'd2, 4'd5, 2'd3, 22'd1);
    b_msg = msg(4'd2, 4'd5, 2'd3, 22'd2);
    ob_ready[1] = 1'b0;
    send(0, a_msg);
    ib_data[0]  = b_msg;
    ib_valid[0] = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      #1;
      if (ib_ready[0]) seen = 1'b1;
      @(negedge clk_i);
    end
    check("stall_ib_ready", seen, 0);
    check("stall_hold_valid", ob_valid[1], 1);
    check("stall_hold_data", ob_d_e, a_msg);
    ob_ready[1] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (ib_ready[0]) seen = 1'b1;
      @(negedge clk_i);
    end
    ib_valid[0] = 1'b0;
    check("stall_release_accept", seen, 1);
    repeat (4) @(negedge clk_i);
    check("stall_deliver_count", xfer_log.size(), 2);
    check("stall_deliver_first", xfer_log[0], {2'd1, a_msg});
    check("stall_deliver_second", xfer_log[1], {2'd1, b_msg});

    // All four inbound valid: grants rotate N,E,S,W and wrap to N.
    do_reset();
    for (int p = 0; p < 4; p++) ib_data[p] = msg(4'd2, 4'd2, 2'd3, 22'(p));
    ib_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr_grant_%0d", k), ib_ready, 4'b0001 << (k % 4));
      @(negedge clk_i);
    end
    ib_valid = 4'h0;

    // Reset during execution, then trigger with an empty program.
    do_reset();
    ob_ready[1] = 1'b0;
    send(0, msg(4'd2, 4'd5, 2'd3, 22'h11));
    local_cmd(2'd2, map_pay(3'd0, 4'd0, 4'd2, 3'd0));
    for (int i = 0; i < 6; i++) local_cmd(2'd0, {7'd0, I_NOT0});
    pulse_trigger();
    @(negedge clk_i);
    rst_i       = 1'b1;
    dmsg        = msg(4'd0, 4'd2, 2'd3, 22'h3);
    ib_data[0]  = dmsg;
    ib_valid[0] = 1'b1;
    #1;
    check("midrst_ob_valid", ob_valid, 4'h0);
    check("midrst_ob_east_data", ob_d_e, 32'h0);
    check("midrst_ib_ready", ib_ready, 4'h0);
    @(negedge clk_i);
    ib_valid = 4'h0;
    ob_ready = 4'hF;
    @(negedge clk_i);
    rst_i = 1'b0;
    xfer_log.delete();
    local_cmd(2'd2, map_pay(3'd0, 4'd0, 4'd2, 3'd0));
    pulse_trigger();
    repeat (20) @(negedge clk_i);
    check("empty_program_silent", xfer_log.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
